// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch controller.
package fetch_pkg;

    // Controller states: idle/probe, address phase, data phase, response hold
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } fetch_state_t;

    // Read response code that means the refill data is good
    localparam logic [1:0] RESP_OKAY = 2'b00;

    // Word address: byte address with the two always-zero bits dropped
    typedef logic [31:2] word_addr_t;

    // Expand a word address to the byte address seen on the memory bus
    function automatic logic [31:0] word_to_byte(input word_addr_t waddr);
        return {waddr, 2'b00};
    endfunction

endpackage

// File: rtl/icache_fetch_sat_counter.sv
// Saturating up-counter used for the hit/miss performance counters.
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_r;

    // Count up on inc and stick at all-ones instead of wrapping
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= '0;
        end else if (inc && (count_r != {CNT_W{1'b1}})) begin
            count_r <= count_r + CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/icache_fetch.sv
// Fetch controller between the core fetch port and a direct-mapped icache.
// Hits answer the cycle after acceptance; misses do one single-word memory
// read, refill the line on OKAY and answer. kill drops the pending response
// but never aborts a bus read that has already been accepted.
module icache_fetch
    import fetch_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [29:0]      req_addr,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [31:0]      resp_inst,
    output logic             resp_err,
    input  logic             kill,
    output logic [29:0]      ic_addr,
    input  logic             ic_is_hit,
    input  logic [31:0]      ic_rdata,
    output logic             ic_wen,
    output logic [31:0]      ic_wdata,
    output logic             mem_arvalid,
    input  logic             mem_arready,
    output logic [31:0]      mem_araddr,
    input  logic             mem_rvalid,
    output logic             mem_rready,
    input  logic [31:0]      mem_rdata,
    input  logic [1:0]       mem_rresp,
    output logic [CNT_W-1:0] hit_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    fetch_state_t state_r;
    fetch_state_t state_nxt_s;
    word_addr_t   addr_r;
    logic [31:0]  inst_r;
    logic         err_r;
    logic         killed_r;

    logic accept_s;
    logic hit_acc_s;
    logic miss_acc_s;
    logic beat_s;
    logic okay_s;

    assign accept_s   = (state_r == IDLE) && req_valid && !kill;
    assign hit_acc_s  = accept_s && ic_is_hit;
    assign miss_acc_s = accept_s && !ic_is_hit;
    assign beat_s     = (state_r == DATA) && mem_rvalid;
    assign okay_s     = (mem_rresp == RESP_OKAY);

    // Next-state selection for the fetch FSM
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_nxt_s = ic_is_hit ? RESP : ADDR;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ADDR: begin
                if (mem_arready) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = ADDR;
                end
            end
            DATA: begin
                if (mem_rvalid) begin
                    state_nxt_s = (killed_r || kill) ? IDLE : RESP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            RESP: begin
                if (kill || resp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture the fetch address when a request is accepted
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            addr_r <= '0;
        end else if (accept_s) begin
            addr_r <= req_addr;
        end else begin
            addr_r <= addr_r;
        end
    end

    // Response word/error: from the icache on a hit, from the bus on a refill
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            inst_r <= 32'h0000_0000;
            err_r  <= 1'b0;
        end else if (hit_acc_s) begin
            inst_r <= ic_rdata;
            err_r  <= 1'b0;
        end else if (beat_s) begin
            inst_r <= okay_s ? mem_rdata : 32'h0000_0000;
            err_r  <= !okay_s;
        end else begin
            inst_r <= inst_r;
            err_r  <= err_r;
        end
    end

    // Remember a kill that arrived while the bus read is still in flight
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            killed_r <= 1'b0;
        end else if (beat_s) begin
            killed_r <= 1'b0;
        end else if (kill && ((state_r == ADDR) || (state_r == DATA))) begin
            killed_r <= 1'b1;
        end else begin
            killed_r <= killed_r;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (hit_acc_s),
        .count (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (miss_acc_s),
        .count (miss_cnt)
    );

    // Outputs are decoded from the state register and the latched datapath
    assign req_ready   = (state_r == IDLE) && !kill;
    assign resp_valid  = (state_r == RESP);
    assign resp_inst   = inst_r;
    assign resp_err    = err_r;
    assign ic_addr     = (state_r == IDLE) ? req_addr : addr_r;
    assign ic_wen      = beat_s && okay_s;
    assign ic_wdata    = mem_rdata;
    assign mem_arvalid = (state_r == ADDR);
    assign mem_araddr  = word_to_byte(addr_r);
    assign mem_rready  = (state_r == DATA);

endmodule

// File: tb/tb_icache_fetch.sv
// Scoreboard bench for icache_fetch: a reference model predicts each
// accepted fetch's result from memory contents and its own view of which
// lines are cached; a monitor pops and compares on every response handshake.
module tb_icache_fetch;
    import fetch_pkg::*;

    localparam int CNT_W = 32;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [29:0]      req_addr = 30'h0;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [31:0]      resp_inst;
    logic             resp_err;
    logic             kill = 1'b0;
    logic [29:0]      ic_addr;
    logic             ic_is_hit;
    logic [31:0]      ic_rdata;
    logic             ic_wen;
    logic [31:0]      ic_wdata;
    logic             mem_arvalid;
    logic             mem_arready = 1'b0;
    logic [31:0]      mem_araddr;
    logic             mem_rvalid = 1'b0;
    logic             mem_rready;
    logic [31:0]      mem_rdata = 32'h0;
    logic [1:0]       mem_rresp = 2'b00;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] miss_cnt;

    icache_fetch #(.CNT_W(CNT_W)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_inst(resp_inst), .resp_err(resp_err), .kill(kill),
        .ic_addr(ic_addr), .ic_is_hit(ic_is_hit), .ic_rdata(ic_rdata),
        .ic_wen(ic_wen), .ic_wdata(ic_wdata),
        .mem_arvalid(mem_arvalid), .mem_arready(mem_arready), .mem_araddr(mem_araddr),
        .mem_rvalid(mem_rvalid), .mem_rready(mem_rready),
        .mem_rdata(mem_rdata), .mem_rresp(mem_rresp),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    typedef struct {
        logic [31:0] inst;
        logic        err;
    } exp_t;

    exp_t sb[$];
    logic plan[$];

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;
    int cyc = 0;

    // stimulus knobs
    bit          rand_mode = 1'b0;
    int          rand_left = 0;
    int          ar_lat = 0;
    int          r_lat = 0;
    int          rr_lat = 0;
    logic        dir_err = 1'b0;
    logic        kill_req = 1'b0;
    logic        req_pending = 1'b0;
    logic [29:0] want_addr = 30'h0;

    // bench-owned icache array (driven by ic_wen) and the model's cache view
    logic        tv[16];
    logic [29:0] tt[16];
    logic [31:0] td[16];
    logic        mv[16];
    logic [29:0] mt[16];

    // observation counters
    int exp_hit = 0, exp_miss = 0, exp_wen = 0;
    int wen_pulses = 0, ar_count = 0, rv_samples = 0;
    int last_lat = -1, accept_cyc = 0;
    int resp_changed = 0, resp_dropped = 0, ar_unstable = 0;
    logic [31:0] last_araddr = 32'h0;
    logic [31:0] last_inst = 32'h0;
    logic        last_err = 1'b0;

    // memory slave state
    int          ms_state = 0, ar_cnt = 0, rd_cnt = 0;
    logic [29:0] cur_addr = 30'h0;
    logic        cur_err = 1'b0;
    logic [1:0]  cur_code = 2'b00;
    logic        pav = 1'b0;
    logic [31:0] paddr = 32'h0;

    // response monitor state
    int          rv_cnt = 0;
    logic        pv = 1'b0, pend = 1'b0, perr = 1'b0;
    logic [31:0] pinst = 32'h0;
    exp_t        mon_e;

    // model scratch
    int          m_idx;
    logic        m_err;
    exp_t        m_e;

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    assign ic_is_hit = tv[ic_addr[3:0]] && (tt[ic_addr[3:0]] == ic_addr);
    assign ic_rdata  = td[ic_addr[3:0]];

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h100) return 32'h0013_0513;
        return {a[13:0], 2'b01, ~a[15:0]} ^ 32'h5a5a_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_caches();
        for (int i = 0; i < 16; i++) begin
            tv[i] = 1'b0; tt[i] = 30'h0; td[i] = 32'h0;
            mv[i] = 1'b0; mt[i] = 30'h0;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic fetch(input logic [29:0] a);
        want_addr   = a;
        req_pending = 1'b1;
        for (int k = 0; k < 200 && req_pending; k++) tick();
        if (req_pending) begin
            check("accept_timeout", 64'd1, 64'd0);
            req_pending = 1'b0;
        end
    endtask

    task automatic wait_quiet(input string tag);
        int k;
        for (k = 0; k < 400; k++) begin
            tick();
            if (!req_pending && sb.size() == 0 && ms_state == 0 &&
                !resp_valid && !mem_arvalid && !mem_rready) break;
        end
        if (k == 400) check(tag, 64'd1, 64'd0);
    endtask

    // which: 0 mem_rready high, 1 resp_valid high, 2 mem_arvalid high, 3 mem_rready low
    task automatic wait_sig(input int which, input string tag);
        logic hit;
        int   k;
        for (k = 0; k < 200; k++) begin
            tick();
            case (which)
                0: hit = mem_rready;
                1: hit = resp_valid;
                2: hit = mem_arvalid;
                default: hit = !mem_rready;
            endcase
            if (hit) break;
        end
        if (k == 200) check(tag, 64'd1, 64'd0);
    endtask

    // kill driver
    initial forever begin
        @(negedge clock);
        if (!reset) kill = 1'b0;
        else if (rand_mode) kill = ($urandom_range(0, 15) == 0);
        else kill = kill_req;
    end

    // request driver: holds req_valid until accepted
    initial forever begin
        @(negedge clock);
        if (rand_mode && !req_pending && rand_left > 0 && $urandom_range(0, 2) == 0) begin
            want_addr   = 30'h100 + 30'($urandom_range(0, 47));
            req_pending = 1'b1;
            rand_left--;
        end
        req_valid = req_pending && reset;
        req_addr  = req_pending ? want_addr : 30'($urandom);
        #4;
        if (req_valid && req_ready) req_pending = 1'b0;
    end

    // response-ready driver with per-response backpressure
    initial forever begin
        @(negedge clock);
        resp_ready = (rv_cnt >= rr_lat);
        #4;
        if (!reset) begin
            rv_cnt = 0;
        end else if (resp_valid) begin
            if (resp_ready || kill) begin
                rv_cnt = 0;
                if (rand_mode) rr_lat = $urandom_range(0, 3);
            end else begin
                rv_cnt++;
            end
        end
    end

    // memory read slave
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            ms_state = 0; ar_cnt = 0; pav = 1'b0;
            mem_arready = 1'b0; mem_rvalid = 1'b0;
        end else begin
            mem_arready = (ms_state == 0) && (ar_cnt >= ar_lat);
            mem_rvalid  = (ms_state == 2);
            mem_rdata   = (ms_state == 2) ? (cur_err ? 32'hdead_beef : mem_word(cur_addr)) : 32'($urandom);
            mem_rresp   = (ms_state == 2) ? cur_code : 2'($urandom);
            #4;
            if (reset) begin
                if (ms_state == 0) begin
                    if (pav && (!mem_arvalid || mem_araddr !== paddr)) ar_unstable++;
                    pav   = mem_arvalid && !mem_arready;
                    paddr = mem_araddr;
                    if (mem_arvalid) begin
                        if (mem_arready) begin
                            ar_count++;
                            last_araddr = mem_araddr;
                            cur_addr    = mem_araddr[31:2];
                            if (plan.size() > 0) begin
                                cur_err = plan.pop_front();
                            end else begin
                                check("unexpected_ar", 64'd1, 64'd0);
                                cur_err = 1'b0;
                            end
                            cur_code = cur_err ? 2'($urandom_range(1, 3)) : RESP_OKAY;
                            rd_cnt   = 0;
                            ms_state = 1;
                        end else begin
                            ar_cnt++;
                        end
                    end
                end else if (ms_state == 1) begin
                    pav = 1'b0;
                    rd_cnt++;
                    if (rd_cnt >= r_lat) ms_state = 2;
                end else if (mem_rready) begin
                    ms_state = 0;
                    ar_cnt   = 0;
                    if (rand_mode) begin
                        ar_lat = $urandom_range(0, 3);
                        r_lat  = $urandom_range(0, 4);
                    end
                end
            end
        end
    end

    // reference model: predicts each accepted fetch, tracks refills and kills
    initial forever begin
        @(negedge clock);
        #4;
        if (reset) begin
            if (ic_wen) begin
                wen_pulses++;
                check("ic_wdata", ic_wdata, mem_word(ic_addr));
                tv[ic_addr[3:0]] = 1'b1;
                tt[ic_addr[3:0]] = ic_addr;
                td[ic_addr[3:0]] = ic_wdata;
            end
            if (req_valid && req_ready) begin
                m_idx      = int'(req_addr[3:0]);
                accept_cyc = cyc;
                if (mv[m_idx] && mt[m_idx] == req_addr) begin
                    exp_hit++;
                    m_e.inst = mem_word(req_addr);
                    m_e.err  = 1'b0;
                end else begin
                    m_err = rand_mode ? ($urandom_range(0, 4) == 0) : dir_err;
                    exp_miss++;
                    plan.push_back(m_err);
                    if (!m_err) begin
                        mv[m_idx] = 1'b1;
                        mt[m_idx] = req_addr;
                        exp_wen++;
                    end
                    m_e.inst = m_err ? 32'h0 : mem_word(req_addr);
                    m_e.err  = m_err;
                end
                sb.push_back(m_e);
            end else if (kill && sb.size() > 0) begin
                void'(sb.pop_back());
            end
        end
    end

    // response monitor: pops the scoreboard on every delivered response
    initial forever begin
        @(negedge clock);
        #4;
        if (!reset) begin
            pv = 1'b0; pend = 1'b0;
        end else begin
            if (resp_valid) begin
                rv_samples++;
                if (!pv || pend) last_lat = cyc - accept_cyc;
                else if (resp_inst !== pinst || resp_err !== perr) resp_changed++;
                if (resp_ready && !kill) begin
                    if (sb.size() == 0) begin
                        check("unexpected_resp", 64'd1, 64'd0);
                    end else begin
                        mon_e = sb.pop_front();
                        check("resp_inst", resp_inst, mon_e.inst);
                        check("resp_err", resp_err, mon_e.err);
                    end
                    last_inst = resp_inst;
                    last_err  = resp_err;
                end
            end else if (pv && !pend) begin
                resp_dropped++;
            end
            pend  = resp_valid && (resp_ready || kill);
            pv    = resp_valid;
            pinst = resp_inst;
            perr  = resp_err;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1);
    end

    initial begin
        int w0, a0, rv0;
        clear_caches();
        repeat (3) tick();
        check("rst_req_ready", req_ready, 1);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_inst", resp_inst, 0);
        check("rst_resp_err", resp_err, 0);
        check("rst_arvalid", mem_arvalid, 0);
        check("rst_rready", mem_rready, 0);
        check("rst_ic_wen", ic_wen, 0);
        check("rst_hit_cnt", hit_cnt, 0);
        check("rst_miss_cnt", miss_cnt, 0);
        reset = 1'b1;
        tick();

        // cold miss
        r_lat = 3; w0 = wen_pulses;
        fetch(30'h100);
        wait_quiet("t1_timeout");
        check("t1_araddr", last_araddr, 32'h400);
        check("t1_wen", wen_pulses - w0, 1);
        check("t1_inst", last_inst, 32'h0013_0513);
        check("t1_miss_cnt", miss_cnt, 1);
        r_lat = 0;

        // same address now hits
        a0 = ar_count;
        fetch(30'h100);
        wait_quiet("t2_timeout");
        check("t2_latency", last_lat, 1);
        check("t2_no_ar", ar_count - a0, 0);
        check("t2_hit_cnt", hit_cnt, 1);
        check("t2_inst", last_inst, 32'h0013_0513);

        // address and response backpressure
        ar_lat = 5; rr_lat = 4;
        fetch(30'h208);
        wait_quiet("t3_timeout");
        check("t3_araddr", last_araddr, 32'h820);
        check("t3_ar_stable", ar_unstable, 0);
        check("t3_resp_stable", resp_changed, 0);
        check("t3_resp_held", resp_dropped, 0);
        check("t3_inst", last_inst, mem_word(30'h208));
        ar_lat = 0; rr_lat = 0;

        // bus error
        dir_err = 1'b1; w0 = wen_pulses;
        fetch(30'h0C3);
        wait_quiet("t4_timeout");
        check("t4_no_wen", wen_pulses - w0, 0);
        check("t4_err", last_err, 1);
        check("t4_inst", last_inst, 0);
        check("t4_miss_cnt", miss_cnt, 3);
        dir_err = 1'b0;

        // kill during DATA: refill still happens, no response
        r_lat = 6; w0 = wen_pulses; rv0 = rv_samples;
        fetch(30'h0D5);
        wait_sig(0, "t5_data_timeout");
        kill_req = 1'b1;
        tick();
        kill_req = 1'b0;
        wait_sig(3, "t5_beat_timeout");
        check("t5_req_ready", req_ready, 1);
        check("t5_resp_valid", resp_valid, 0);
        wait_quiet("t5_timeout");
        check("t5_wen", wen_pulses - w0, 1);
        check("t5_no_resp", rv_samples - rv0, 0);
        r_lat = 0;

        // kill during RESP: resp_valid drops next cycle
        rr_lat = 6;
        fetch(30'h100);
        wait_sig(1, "t6_resp_timeout");
        kill_req = 1'b1;
        tick();
        kill_req = 1'b0;
        check("t6_resp_dropped", resp_valid, 0);
        check("t6_hit_cnt", hit_cnt, 2);
        rr_lat = 0;
        wait_quiet("t6_timeout");

        // reset while in ADDR
        ar_lat = 10;
        fetch(30'h1E7);
        wait_sig(2, "t7_addr_timeout");
        #1;
        reset = 1'b0;
        #1;
        check("t7_arvalid", mem_arvalid, 0);
        check("t7_hit_cnt", hit_cnt, 0);
        check("t7_miss_cnt", miss_cnt, 0);
        check("t7_resp_valid", resp_valid, 0);
        sb.delete(); plan.delete(); clear_caches();
        exp_hit = 0; exp_miss = 0; exp_wen = 0; wen_pulses = 0;
        ar_lat = 0;
        tick(); tick();
        reset = 1'b1;
        tick();
        fetch(30'h100);
        wait_quiet("t7b_timeout");
        check("t7_post_miss", miss_cnt, 1);
        check("t7_post_inst", last_inst, 32'h0013_0513);

        // randomized traffic with random kills and backpressure
        rand_left = 250;
        rand_mode = 1'b1;
        for (int k = 0; k < 20000 && (rand_left > 0 || req_pending); k++) tick();
        rand_mode = 1'b0;
        wait_quiet("rand_timeout");
        check("rand_hit_cnt", hit_cnt, exp_hit);
        check("rand_miss_cnt", miss_cnt, exp_miss);
        check("rand_wen", wen_pulses, exp_wen);
        check("rand_ar_stable", ar_unstable, 0);
        check("rand_resp_stable", resp_changed, 0);
        check("rand_resp_held", resp_dropped, 0);
        check("rand_plan_empty", plan.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/icache_fetch.md
Name: icache_fetch

Overview:
- Fetch controller between the core's instruction-fetch port and the direct-mapped icache.
- On each fetch it probes the icache combinationally; a hit returns the word directly.
- On a miss it issues a single-word read on the memory read channel, refills the icache line and returns the word.
- Supports a kill (branch redirect) that discards the in-flight response, and keeps hit/miss counters.

Parameters:
CNT_W  32  width of the saturating hit/miss performance counters
RESP_OKAY  2'b00  mem_rresp value treated as success

Ports:
clock  in  1  single clock, rising edge
reset  in  1  asynchronous, active-low (asserted at 0); all state cleared immediately
req_valid  in  1  core fetch request valid
req_ready  out  1  controller can accept a request
req_addr  in  30  word address [31:2] to fetch
resp_valid  out  1  fetched instruction valid
resp_ready  in  1  core accepts response
resp_inst  out  32  fetched instruction word
resp_err  out  1  bus error on refill; resp_inst is 0
kill  in  1  redirect: drop pending/in-flight response
ic_addr  out  30  icache lookup/write address [31:2]
ic_is_hit  in  1  icache hit for ic_addr
ic_rdata  in  32  icache hit data
ic_wen  out  1  icache write strobe (one cycle per refill)
ic_wdata  out  32  icache write data
mem_arvalid  out  1  read address valid
mem_arready  in  1  read address accepted
mem_araddr  out  32  byte address, {addr,2'b00}
mem_rvalid  in  1  read data valid
mem_rready  out  1  ready for read data
mem_rdata  in  32  read data
mem_rresp  in  2  read response code
hit_cnt  out  CNT_W  accepted requests that hit; saturates at all-ones
miss_cnt  out  CNT_W  accepted requests that missed; saturates

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_inst=0, resp_err=0, mem_arvalid=0, mem_rready=0, ic_wen=0, killed=0, counters 0.
- States: IDLE, ADDR, DATA, RESP.
- ic_addr is req_addr in IDLE, otherwise the latched address.
- IDLE:
  - req_ready = !kill. A request is accepted when req_valid && req_ready; the address is latched.
  - On a hit: latch ic_rdata, set resp_err=0, hit_cnt++, go to RESP (hit latency: resp_valid the cycle after acceptance).
  - On a miss: miss_cnt++, go to ADDR.
- ADDR:
  - mem_arvalid=1, held stable until mem_arready.
  - On handshake go to DATA.
- DATA:
  - mem_rready=1. On mem_rvalid:
    - If mem_rresp==RESP_OKAY: ic_wen=1 for exactly that cycle, ic_wdata=mem_rdata; latch the data with resp_err=0.
    - Else: no icache write; latch inst=0 with resp_err=1.
  - Then go to RESP, or go to IDLE if killed is set (or kill is high in that cycle); clear killed.
- RESP:
  - resp_valid=1, with resp_inst and resp_err held stable until resp_ready.
  - On resp_ready go to IDLE. No back-to-back acceptance in the same cycle.
- kill:
  - In RESP: resp_valid drops next cycle and state goes to IDLE. kill has priority over a concurrent resp_ready; either way the transaction ends.
  - In ADDR/DATA: set killed. The bus transaction still completes and the icache is still refilled on OKAY, but no response is presented.
  - In IDLE: blocks acceptance for that cycle.
- Counters increment only on acceptance and saturate at 2^CNT_W-1; kill does not undo them.
- Reset mid-refill: all outputs return to reset values immediately. Any outstanding bus beat is the interconnect's responsibility (bus is reset by the same reset).
- One outstanding memory read at most; no prefetch.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, ADDR, DATA, RESP}; RESP_OKAY constant; word-address typedef logic [31:2].
- One sub-module, sat_counter (CNT_W, inc, count), instantiated for hit_cnt and miss_cnt.
- FSM and datapath stay in icache_fetch.

Test Plan:
- Cold miss: req 0x0000_0400>>2, memory returns 0x0013_0513 OKAY after 3 cycles. Required: mem_araddr=0x400, one ic_wen pulse, resp_inst=0x0013_0513, miss_cnt=1.
- Repeat the same address with the icache model hit. Required: resp_valid exactly 1 cycle after acceptance, no mem_arvalid, hit_cnt=1.
- Backpressure: mem_arready low 5 cycles, then resp_ready low 4 cycles. Required: mem_araddr stable throughout, resp_inst/resp_valid held until ready.
- Bus error: mem_rresp=2'b10. Required: ic_wen never asserts, resp_err=1, resp_inst=0.
- Kill during DATA. Required: the refill write still occurs, resp_valid stays 0, req_ready=1 the following cycle. Also kill during RESP: resp_valid drops next cycle.
- Reset (reset=0) asserted while in ADDR. Required: mem_arvalid=0 immediately, counters 0, and a normal fetch works after release.
